mem_strb_ctrl: RTL and testbench
================================

Name: mem_strb_ctrl

Overview:
Second-generation single-port synchronous memory with a valid/ready request interface.
- Adds per-byte write strobes, a registered read response channel with backpressure (rvalid_o/rready_i), out-of-range error reporting and a self-clearing init sequence after reset.
- Sits between a bus master and local storage; drop-in successor to the basic WIDTH/DEPTH memory.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address width in bits.
- STRB_WIDTH, WIDTH/8, number of byte strobes; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state changes on posedge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  request valid.
- ready_o  output  1  request accepted when valid_i && ready_o at posedge.
- wr_rd_i  input  1  1 = write, 0 = read.
- addr_i  input  ADDR_WIDTH  word address.
- wdata_i  input  WIDTH  write data.
- wstrb_i  input  STRB_WIDTH  byte enables for writes; bit k covers wdata_i[8k+7:8k].
- rdata_o  output  WIDTH  read data; valid while rvalid_o=1.
- rvalid_o  output  1  read response valid.
- rready_i  input  1  response consumed when rvalid_o && rready_i at posedge.
- err_o  output  1  out-of-range access flag.
- init_done_o  output  1  high once the memory clear has completed.

Behaviour:
- Reset, asynchronous, while rst_i=1: ready_o=0, rvalid_o=0, rdata_o=0, err_o=0, init_done_o=0, state=INIT, clear counter=0.
- States are INIT, IDLE and RESP.
- INIT: writes 0 to mem[cnt] each cycle, then cnt++.
  - After the write of DEPTH-1, go to IDLE; init_done_o=1 from the first IDLE cycle onward.
  - ready_o=0 throughout INIT.
  - Inputs are ignored during INIT.
- ready_o is combinational: ready_o = (state==IDLE), unless the optional feature is enabled.
- IDLE, write handshake:
  - For each k with wstrb_i[k]=1, mem[addr_i] byte k <= wdata_i byte k. Other bytes are unchanged.
  - State stays IDLE, so back-to-back writes are accepted one per cycle.
  - wstrb_i=0 completes the handshake and changes nothing.
- IDLE, read handshake:
  - rdata_o <= mem[addr_i] and rvalid_o <= 1 at the same edge, giving 1-cycle latency. State goes to RESP.
- RESP:
  - rdata_o, rvalid_o and err_o are held stable until rready_i=1 at a posedge.
  - At that edge rvalid_o <= 0, err_o <= 0, and state goes to IDLE.
- Read-after-write to the same address on consecutive handshakes returns the new data.
- Out of range (addr_i >= DEPTH):
  - The handshake still completes.
  - A write is dropped and err_o pulses high for exactly 1 cycle.
  - A read returns rdata_o=0 with err_o=1, held together with rvalid_o.
- In-range accesses drive err_o=0.
- Reset mid-operation: all outputs return immediately to their reset values, any pending response is discarded, and INIT re-clears the whole memory.
- X on valid_i is not permitted after init_done_o=1.

Optional Feature:
Macro is MEM_PIPE_READ_EN.
- Defined:
  - ready_o = (state==IDLE) || (state==RESP && rready_i).
  - A new request is accepted in the same cycle the current response is consumed.
  - A new read reloads rdata_o/rvalid_o/err_o and stays in RESP.
  - A new write performs the write and goes to IDLE with rvalid_o <= 0.
  - Sustained reads with rready_i=1 give 1 read per cycle.
- Not defined:
  - ready_o = (state==IDLE) only, so the maximum read rate is 1 per 2 cycles.
  - There is no combinational path from rready_i to ready_o.

Test Plan:
1. Init clear, default params: hold rst_i 2 cycles, release.
   - init_done_o rises exactly 64 cycles after release, with ready_o=0 until then.
   - A read of addr 5 returns 0x0000 with err_o=0.
2. Basic write/read: write 0xA5A5, wstrb=2'b11, to addr 3, then read addr 3 with rready_i=1.
   - rvalid_o=1 and rdata_o=0xA5A5 in the cycle after the read handshake.
   - rvalid_o drops on the next edge.
3. Byte strobes:
   - Write 0x1234 to addr 7, then 0xFF00 with wstrb=2'b10, then read addr 7. Required: 0xFF34.
   - Write 0xABCD with wstrb=2'b00, then read addr 7. Required: still 0xFF34.
4. Backpressure: read addr 3 with rready_i=0 for 5 cycles.
   - rvalid_o=1 and rdata_o=0xA5A5 stay stable, and ready_o=0.
   - Raise rready_i: rvalid_o=0 after that edge and ready_o=1.
   - With MEM_PIPE_READ_EN, issue a read of addr 7 in that same cycle: rdata_o=0xFF34 next cycle with no bubble.
5. Out of range, DEPTH=48:
   - Read addr 50: rdata_o=0, err_o=1 alongside rvalid_o.
   - Write 0xFFFF to addr 60: err_o pulses 1 cycle.
   - A subsequent read of addr 12 (60 mod 48) returns 0.
6. Reset mid-response: assert rst_i while rvalid_o=1.
   - rvalid_o, rdata_o, err_o, init_done_o and ready_o go to 0 asynchronously.
   - After re-init, reading addr 3 returns 0x0000.

Source files
------------

// File: rtl/mem_strb_ctrl_if.sv
// Request/response bus for mem_strb_ctrl.
// The master drives the request and rready_i. The slave drives ready_o and the response.
interface mem_strb_ctrl_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 6
);
    localparam int unsigned STRB_WIDTH = WIDTH / 8;

    logic                  valid_i;
    logic                  ready_o;
    logic                  wr_rd_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [WIDTH-1:0]      wdata_i;
    logic [STRB_WIDTH-1:0] wstrb_i;
    logic [WIDTH-1:0]      rdata_o;
    logic                  rvalid_o;
    logic                  rready_i;
    logic                  err_o;
    logic                  init_done_o;

    modport master (
        output valid_i, wr_rd_i, addr_i, wdata_i, wstrb_i, rready_i,
        input  ready_o, rdata_o, rvalid_o, err_o, init_done_o
    );

    modport slave (
        input  valid_i, wr_rd_i, addr_i, wdata_i, wstrb_i, rready_i,
        output ready_o, rdata_o, rvalid_o, err_o, init_done_o
    );
endinterface

// File: rtl/mem_strb_ctrl.sv
// Single-port synchronous memory with byte strobes and a registered read response.
// The read response has backpressure. Out-of-range accesses are flagged.
// After reset, the memory clears itself before it accepts requests.
// Optional macro MEM_PIPE_READ_EN lets a new request be accepted in the same cycle
// that the current response is consumed.
module mem_strb_ctrl #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_strb_ctrl_if.slave bus
);
    localparam int unsigned STRB_WIDTH = WIDTH / 8;
    // One extra bit so that DEPTH = 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {StInit, StIdle, StResp} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [STRB_WIDTH-1:0] mem_be;

    logic                  ready;
    logic                  hs;
    logic                  in_range;
    logic [WIDTH-1:0]      rd_word;

    // Request acceptance, address range check and read data
    always_comb begin
        ready = 1'b0;
`ifdef MEM_PIPE_READ_EN
        ready = (state_q == StIdle) || ((state_q == StResp) && bus.rready_i);
`else
        ready = (state_q == StIdle);
`endif
        hs       = bus.valid_i && ready;
        in_range = ({1'b0, bus.addr_i} < DepthExt);
        rd_word  = '0;
        if (in_range) begin
            rd_word = mem_q[bus.addr_i];
        end
    end

    // Next state, response registers and memory write port
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = bus.addr_i;
        mem_wdata = bus.wdata_i;
        mem_be    = bus.wstrb_i;

        unique case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                mem_be    = '1;
                if (cnt_q == LastAddr) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIdle: begin
                // A write error pulses for a single cycle only.
                err_d = 1'b0;
            end
            StResp: begin
                if (bus.rready_i) begin
                    rvalid_d = 1'b0;
                    err_d    = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // ready gating means hs can only occur in StIdle, or in StResp while the response drains.
        if (hs) begin
            err_d = !in_range;
            if (bus.wr_rd_i) begin
                mem_we   = in_range;
                rvalid_d = 1'b0;
                state_d  = StIdle;
            end else begin
                rdata_d  = rd_word;
                rvalid_d = 1'b1;
                state_d  = StResp;
            end
        end
    end

    // Control and response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StInit;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    // Storage array: byte-masked writes, no reset (cleared by the init sequence)
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < int'(STRB_WIDTH); k++) begin
            if (mem_we && mem_be[k]) begin
                mem_q[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    assign bus.ready_o     = ready;
    assign bus.rdata_o     = rdata_q;
    assign bus.rvalid_o    = rvalid_q;
    assign bus.err_o       = err_q;
    assign bus.init_done_o = (state_q != StInit);
endmodule

// File: tb/tb_mem_strb_ctrl.sv
// Directed self-checking bench for mem_strb_ctrl.
// It instantiates a default 64-word memory and a 48-word memory for the out-of-range cases.
module tb_mem_strb_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mem_strb_ctrl_if #(.WIDTH(16), .ADDR_WIDTH(6)) bus ();
    mem_strb_ctrl_if #(.WIDTH(16), .ADDR_WIDTH(6)) bus48 ();

    mem_strb_ctrl #(.WIDTH(16), .DEPTH(64), .ADDR_WIDTH(6)) u_dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    mem_strb_ctrl #(.WIDTH(16), .DEPTH(48), .ADDR_WIDTH(6)) u_dut48 (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus48)
    );

    // Drive one request and wait, up to a bound, for its handshake edge.
    // Returns 1 time unit after the accepting posedge.
    task automatic req(input bit b48, input logic wr, input logic [5:0] a,
                       input logic [15:0] d, input logic [1:0] s);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        if (b48) begin
            bus48.valid_i = 1'b1; bus48.wr_rd_i = wr; bus48.addr_i = a;
            bus48.wdata_i = d;    bus48.wstrb_i = s;
        end else begin
            bus.valid_i = 1'b1; bus.wr_rd_i = wr; bus.addr_i = a;
            bus.wdata_i = d;    bus.wstrb_i = s;
        end
        for (int n = 0; n < 20 && !acc; n++) begin
            #1;
            acc = b48 ? bus48.ready_o : bus.ready_o;
            @(posedge clk);
        end
        #1;
        bus.valid_i   = 1'b0;
        bus48.valid_i = 1'b0;
        n_total++;
        if (acc !== 1'b1) $display("FAIL handshake_timeout: addr %0d got ready %b want 1", a, acc);
        else n_pass++;
    endtask

    task automatic test_reset();
        int cyc;
        bit early;
        bus.valid_i = 0; bus.wr_rd_i = 0; bus.addr_i = 0; bus.wdata_i = 0; bus.wstrb_i = 0;
        bus.rready_i = 1;
        bus48.valid_i = 0; bus48.wr_rd_i = 0; bus48.addr_i = 0; bus48.wdata_i = 0;
        bus48.wstrb_i = 0; bus48.rready_i = 1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (bus.ready_o !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.ready_o); else n_pass++;
        n_total++; if (bus.rvalid_o !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", bus.rvalid_o); else n_pass++;
        n_total++; if (bus.rdata_o !== 16'h0) $display("FAIL rst_rdata: got %h want 0000", bus.rdata_o); else n_pass++;
        n_total++; if (bus.err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.err_o); else n_pass++;
        n_total++; if (bus.init_done_o !== 1'b0) $display("FAIL rst_init_done: got %b want 0", bus.init_done_o); else n_pass++;
        rst = 1'b0;
        cyc = 0;
        early = 0;
        while (bus.init_done_o !== 1'b1 && cyc < 200) begin
            if (bus.ready_o !== 1'b0) early = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        n_total++; if (cyc != 64) $display("FAIL init_cycles: got %0d want 64", cyc); else n_pass++;
        n_total++; if (early != 0) $display("FAIL init_ready_low: got %0d want 0", early); else n_pass++;
        n_total++; if (bus.ready_o !== 1'b1) $display("FAIL idle_ready: got %b want 1", bus.ready_o); else n_pass++;
        n_total++; if (bus48.init_done_o !== 1'b1) $display("FAIL init48_done: got %b want 1", bus48.init_done_o); else n_pass++;
        req(0, 1'b0, 6'd5, 16'h0, 2'b00);
        n_total++; if (bus.rvalid_o !== 1'b1) $display("FAIL init_rd_rvalid: got %b want 1", bus.rvalid_o); else n_pass++;
        n_total++; if (bus.rdata_o !== 16'h0000) $display("FAIL init_rd_data: got %h want 0000", bus.rdata_o); else n_pass++;
        n_total++; if (bus.err_o !== 1'b0) $display("FAIL init_rd_err: got %b want 0", bus.err_o); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bus.rready_i = 1'b1;
        req(0, 1'b1, 6'd3, 16'hA5A5, 2'b11);
        n_total++; if (bus.err_o !== 1'b0) $display("FAIL basic_wr_err: got %b want 0", bus.err_o); else n_pass++;
        req(0, 1'b0, 6'd3, 16'h0, 2'b00);
        n_total++; if (bus.rvalid_o !== 1'b1) $display("FAIL basic_rvalid: got %b want 1", bus.rvalid_o); else n_pass++;
        n_total++; if (bus.rdata_o !== 16'hA5A5) $display("FAIL basic_rdata: got %h want a5a5", bus.rdata_o); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus.rvalid_o !== 1'b0) $display("FAIL basic_rvalid_drop: got %b want 0", bus.rvalid_o); else n_pass++;
    endtask

    task automatic test_strobes();
        bus.rready_i = 1'b1;
        req(0, 1'b1, 6'd7, 16'h1234, 2'b11);
        req(0, 1'b1, 6'd7, 16'hFF00, 2'b10);
        req(0, 1'b0, 6'd7, 16'h0, 2'b00);
        n_total++; if (bus.rdata_o !== 16'hFF34) $display("FAIL strb_hi: got %h want ff34", bus.rdata_o); else n_pass++;
        @(posedge clk); #1;
        req(0, 1'b1, 6'd7, 16'hABCD, 2'b00);
        req(0, 1'b0, 6'd7, 16'h0, 2'b00);
        n_total++; if (bus.rdata_o !== 16'hFF34) $display("FAIL strb_none: got %h want ff34", bus.rdata_o); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bus.rready_i = 1'b0;
        req(0, 1'b0, 6'd3, 16'h0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            n_total++; if (bus.rvalid_o !== 1'b1) $display("FAIL bp_rvalid[%0d]: got %b want 1", i, bus.rvalid_o); else n_pass++;
            n_total++; if (bus.rdata_o !== 16'hA5A5) $display("FAIL bp_rdata[%0d]: got %h want a5a5", i, bus.rdata_o); else n_pass++;
            n_total++; if (bus.ready_o !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.ready_o); else n_pass++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        bus.rready_i = 1'b1;
`ifdef MEM_PIPE_READ_EN
        bus.valid_i = 1'b1; bus.wr_rd_i = 1'b0; bus.addr_i = 6'd7;
        #1;
        n_total++; if (bus.ready_o !== 1'b1) $display("FAIL pipe_ready: got %b want 1", bus.ready_o); else n_pass++;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        n_total++; if (bus.rvalid_o !== 1'b1) $display("FAIL pipe_rvalid: got %b want 1", bus.rvalid_o); else n_pass++;
        n_total++; if (bus.rdata_o !== 16'hFF34) $display("FAIL pipe_rdata: got %h want ff34", bus.rdata_o); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus.rvalid_o !== 1'b0) $display("FAIL pipe_drain: got %b want 0", bus.rvalid_o); else n_pass++;
`else
        #1;
        n_total++; if (bus.ready_o !== 1'b0) $display("FAIL bp_no_comb_ready: got %b want 0", bus.ready_o); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus.rvalid_o !== 1'b0) $display("FAIL bp_release_rvalid: got %b want 0", bus.rvalid_o); else n_pass++;
        n_total++; if (bus.ready_o !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.ready_o); else n_pass++;
`endif
    endtask

    task automatic test_out_of_range();
        bus48.rready_i = 1'b0;
        req(1, 1'b0, 6'd50, 16'h0, 2'b00);
        n_total++; if (bus48.rvalid_o !== 1'b1) $display("FAIL oor_rd_rvalid: got %b want 1", bus48.rvalid_o); else n_pass++;
        n_total++; if (bus48.rdata_o !== 16'h0) $display("FAIL oor_rd_data: got %h want 0000", bus48.rdata_o); else n_pass++;
        n_total++; if (bus48.err_o !== 1'b1) $display("FAIL oor_rd_err: got %b want 1", bus48.err_o); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus48.err_o !== 1'b1) $display("FAIL oor_rd_err_hold: got %b want 1", bus48.err_o); else n_pass++;
        @(negedge clk);
        bus48.rready_i = 1'b1;
        @(posedge clk); #1;
        n_total++; if (bus48.err_o !== 1'b0) $display("FAIL oor_rd_err_clr: got %b want 0", bus48.err_o); else n_pass++;
        n_total++; if (bus48.rvalid_o !== 1'b0) $display("FAIL oor_rd_rvalid_clr: got %b want 0", bus48.rvalid_o); else n_pass++;
        req(1, 1'b1, 6'd60, 16'hFFFF, 2'b11);
        n_total++; if (bus48.err_o !== 1'b1) $display("FAIL oor_wr_err: got %b want 1", bus48.err_o); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (bus48.err_o !== 1'b0) $display("FAIL oor_wr_err_pulse: got %b want 0", bus48.err_o); else n_pass++;
        req(1, 1'b0, 6'd12, 16'h0, 2'b00);
        n_total++; if (bus48.rdata_o !== 16'h0) $display("FAIL oor_alias_data: got %h want 0000", bus48.rdata_o); else n_pass++;
        n_total++; if (bus48.err_o !== 1'b0) $display("FAIL oor_alias_err: got %b want 0", bus48.err_o); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_resp();
        int cyc;
        bus.rready_i = 1'b0;
        req(0, 1'b0, 6'd3, 16'h0, 2'b00);
        n_total++; if (bus.rvalid_o !== 1'b1) $display("FAIL mid_pre_rvalid: got %b want 1", bus.rvalid_o); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (bus.rvalid_o !== 1'b0) $display("FAIL mid_rvalid: got %b want 0", bus.rvalid_o); else n_pass++;
        n_total++; if (bus.rdata_o !== 16'h0) $display("FAIL mid_rdata: got %h want 0000", bus.rdata_o); else n_pass++;
        n_total++; if (bus.err_o !== 1'b0) $display("FAIL mid_err: got %b want 0", bus.err_o); else n_pass++;
        n_total++; if (bus.init_done_o !== 1'b0) $display("FAIL mid_init_done: got %b want 0", bus.init_done_o); else n_pass++;
        n_total++; if (bus.ready_o !== 1'b0) $display("FAIL mid_ready: got %b want 0", bus.ready_o); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bus.rready_i = 1'b1;
        cyc = 0;
        while (bus.init_done_o !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_total++; if (bus.init_done_o !== 1'b1) $display("FAIL reinit_done: got %b want 1", bus.init_done_o); else n_pass++;
        req(0, 1'b0, 6'd3, 16'h0, 2'b00);
        n_total++; if (bus.rdata_o !== 16'h0000) $display("FAIL reinit_rd3: got %h want 0000", bus.rdata_o); else n_pass++;
        @(posedge clk); #1;
        req(0, 1'b0, 6'd7, 16'h0, 2'b00);
        n_total++; if (bus.rdata_o !== 16'h0000) $display("FAIL reinit_rd7: got %h want 0000", bus.rdata_o); else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobes();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_resp();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
